// File: rtl/yin_pitch_tracker.sv
// YIN pitch tracker: ring-buffered samples, pipelined difference function,
// CMNDF threshold search with dip descent and global-minimum fallback.
module yin_pitch_tracker #(
  parameter int SIG_WIDTH   = 9,
  parameter int WINDOW_SIZE = 500,
  parameter int TAU_MIN     = 8,
  parameter int TAU_MAX     = 80,
  parameter int THR_FRAC    = 16
) (
  input  logic                         clk_in,
  input  logic                         rst_n_in,
  input  logic [SIG_WIDTH-1:0]         sig_in,
  input  logic                         sig_in_valid,
  input  logic                         start_in,
  input  logic [THR_FRAC-1:0]          threshold_in,
  output logic [$clog2(TAU_MAX+1)-1:0] tau_out,
  output logic                         voiced_out,
  output logic                         result_valid_out,
  input  logic                         result_ready_in,
  output logic                         busy_out,
  output logic                         filled_out,
  output logic                         overrun_out
);
  localparam int W     = WINDOW_SIZE - TAU_MAX;
  localparam int TW    = $clog2(TAU_MAX+1);
  localparam int AW    = $clog2(WINDOW_SIZE);
  localparam int AW1   = AW + 1;
  localparam int JW    = $clog2(W+1);
  localparam int FW    = $clog2(WINDOW_SIZE+1);
  localparam int DW    = SIG_WIDTH + 1;
  localparam int SQW   = 2 * DW;
  localparam int ACC_W = 2*DW + $clog2(W) + $clog2(TAU_MAX) + 1;
  localparam int MW    = ACC_W + TW + ACC_W + THR_FRAC;

  typedef enum logic [2:0] {S_IDLE, S_DIFF, S_SEARCH, S_DESCEND, S_DONE} state_e;

  // Compares d'(a) < d'(b), d' = d*tau/S, without division; S = 0 counts as d' = 1.
  function automatic logic dp_lt(input logic [ACC_W-1:0] d_a, input logic [TW-1:0] t_a,
                                 input logic [ACC_W-1:0] s_a, input logic [ACC_W-1:0] d_b,
                                 input logic [TW-1:0] t_b, input logic [ACC_W-1:0] s_b);
    logic [MW-1:0] n_a, m_a, n_b, m_b;
    if (s_a == {ACC_W{1'b0}}) begin
      n_a = MW'(1'b1); m_a = MW'(1'b1);
    end else begin
      n_a = MW'(d_a) * MW'(t_a); m_a = MW'(s_a);
    end
    if (s_b == {ACC_W{1'b0}}) begin
      n_b = MW'(1'b1); m_b = MW'(1'b1);
    end else begin
      n_b = MW'(d_b) * MW'(t_b); m_b = MW'(s_b);
    end
    return (n_a * m_b) < (n_b * m_a);
  endfunction

  logic [SIG_WIDTH-1:0]        mem_q [WINDOW_SIZE];
  logic [ACC_W-1:0]            dmem_q [TAU_MAX+1];
  state_e                      state_q;
  logic [AW-1:0]               wp_q, base_q;
  logic [FW-1:0]               fill_cnt_q;
  logic                        filled_q, overrun_q, busy_q, rvalid_q, voiced_q;
  logic [TW-1:0]               tau_q, tau_out_q, best_tau_q;
  logic [JW-1:0]               j_q;
  logic                        drain_q, best_vld_q;
  logic [THR_FRAC-1:0]         thr_q;
  logic signed [SIG_WIDTH-1:0] xa_q, xb_q;
  logic signed [DW-1:0]        diff_q;
  logic [SQW-1:0]              sq_q;
  logic                        v1_q, l1_q, v2_q, l2_q, v3_q, l3_q;
  logic [ACC_W-1:0]            acc_q, s_q, best_d_q, best_s_q;

  logic                        cap_s, accept_s, ge_min_s, cross_s, better_s, desc_s, dwe_s;
  logic [AW-1:0]               wp_inc_s, ra_s, rb_s;
  logic [AW1-1:0]              sum_a_s, sum_b_s;
  logic signed [SQW-1:0]       dext_s;
  logic [SQW-1:0]              sq_s;
  logic [ACC_W-1:0]            term_s, d_cur_s, d_nx_s, s_cur_s, s_nx_s;
  logic [TW-1:0]               tau_nx_s;

  // Capture/accept decisions, read addressing and search/descent comparisons.
  always_comb begin
    cap_s    = sig_in_valid && (state_q == S_IDLE || state_q == S_DONE);
    wp_inc_s = (wp_q == AW'(WINDOW_SIZE-1)) ? {AW{1'b0}} : wp_q + AW'(1'b1);
    accept_s = start_in && (state_q == S_IDLE) && filled_q;
    sum_a_s  = AW1'(base_q) + AW1'(j_q);
    sum_b_s  = sum_a_s + AW1'(tau_q);
    ra_s     = (sum_a_s >= AW1'(WINDOW_SIZE)) ? AW'(sum_a_s - AW1'(WINDOW_SIZE)) : AW'(sum_a_s);
    rb_s     = (sum_b_s >= AW1'(WINDOW_SIZE)) ? AW'(sum_b_s - AW1'(WINDOW_SIZE)) : AW'(sum_b_s);
    dext_s   = SQW'(diff_q);
    sq_s     = $unsigned(dext_s * dext_s);
    term_s   = acc_q + ACC_W'(sq_q);
    d_cur_s  = dmem_q[tau_q];
    tau_nx_s = (tau_q == TW'(TAU_MAX)) ? tau_q : tau_q + TW'(1'b1);
    d_nx_s   = dmem_q[tau_nx_s];
    s_cur_s  = s_q + d_cur_s;
    s_nx_s   = s_q + d_nx_s;
    ge_min_s = (tau_q >= TW'(TAU_MIN));
    cross_s  = ge_min_s && (s_cur_s != {ACC_W{1'b0}}) &&
               (((MW'(d_cur_s) * MW'(tau_q)) << THR_FRAC) < (MW'(thr_q) * MW'(s_cur_s)));
    better_s = !best_vld_q || dp_lt(d_cur_s, tau_q, s_cur_s, best_d_q, best_tau_q, best_s_q);
    desc_s   = (tau_q != TW'(TAU_MAX)) && dp_lt(d_nx_s, tau_nx_s, s_nx_s, d_cur_s, tau_q, s_q);
    dwe_s    = (state_q == S_DIFF) && v3_q && l3_q;
  end

  // Sample ring buffer; contents survive reset and are only trusted once filled.
  always_ff @(posedge clk_in) begin
    if (cap_s) mem_q[wp_q] <= sig_in;
  end

  // d(tau) table, written once the last term of a lag has left the pipeline.
  always_ff @(posedge clk_in) begin
    if (dwe_s) dmem_q[tau_q] <= term_s;
  end

  // Control FSM, difference pipeline, search state and registered outputs.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q <= S_IDLE;      wp_q <= {AW{1'b0}};      base_q <= {AW{1'b0}};
      fill_cnt_q <= {FW{1'b0}}; filled_q <= 1'b0;      overrun_q <= 1'b0;
      busy_q <= 1'b0;         rvalid_q <= 1'b0;        voiced_q <= 1'b0;
      tau_q <= {TW{1'b0}};    tau_out_q <= {TW{1'b0}}; best_tau_q <= {TW{1'b0}};
      j_q <= {JW{1'b0}};      drain_q <= 1'b0;         best_vld_q <= 1'b0;
      thr_q <= {THR_FRAC{1'b0}};
      xa_q <= {SIG_WIDTH{1'b0}}; xb_q <= {SIG_WIDTH{1'b0}}; diff_q <= {DW{1'b0}};
      sq_q <= {SQW{1'b0}};
      v1_q <= 1'b0; l1_q <= 1'b0; v2_q <= 1'b0; l2_q <= 1'b0; v3_q <= 1'b0; l3_q <= 1'b0;
      acc_q <= {ACC_W{1'b0}}; s_q <= {ACC_W{1'b0}};
      best_d_q <= {ACC_W{1'b0}}; best_s_q <= {ACC_W{1'b0}};
    end else begin
      v1_q <= 1'b0;  l1_q <= 1'b0;
      xa_q <= mem_q[ra_s];  xb_q <= mem_q[rb_s];
      v2_q <= v1_q;  l2_q <= l1_q;  diff_q <= DW'(xa_q) - DW'(xb_q);
      v3_q <= v2_q;  l3_q <= l2_q;  sq_q <= sq_s;
      if (cap_s) begin
        wp_q <= wp_inc_s;
        if (fill_cnt_q != FW'(WINDOW_SIZE)) fill_cnt_q <= fill_cnt_q + FW'(1'b1);
        if (fill_cnt_q == FW'(WINDOW_SIZE-1)) filled_q <= 1'b1;
      end
      if (sig_in_valid && !cap_s) overrun_q <= 1'b1;
      case (state_q)
        S_IDLE: begin
          if (accept_s) begin
            state_q <= S_DIFF;  busy_q <= 1'b1;  overrun_q <= 1'b0;
            thr_q   <= threshold_in;
            base_q  <= cap_s ? wp_inc_s : wp_q;
            tau_q   <= TW'(1'b1);  j_q <= {JW{1'b0}};
            drain_q <= 1'b0;       acc_q <= {ACC_W{1'b0}};
          end
        end
        S_DIFF: begin
          // Issue W pairs per lag, then hold off until the tagged last term is stored.
          if (!drain_q) begin
            v1_q <= 1'b1;
            l1_q <= (j_q == JW'(W-1));
            if (j_q == JW'(W-1)) drain_q <= 1'b1;
            else                 j_q <= j_q + JW'(1'b1);
          end
          if (v3_q) begin
            if (l3_q) begin
              acc_q <= {ACC_W{1'b0}};
              if (tau_q == TW'(TAU_MAX)) begin
                state_q <= S_SEARCH;  tau_q <= TW'(1'b1);
                s_q <= {ACC_W{1'b0}}; best_vld_q <= 1'b0;
              end else begin
                tau_q <= tau_q + TW'(1'b1);  j_q <= {JW{1'b0}};  drain_q <= 1'b0;
              end
            end else begin
              acc_q <= term_s;
            end
          end
        end
        S_SEARCH: begin
          if (cross_s) begin
            state_q <= S_DESCEND;  s_q <= s_cur_s;
          end else begin
            if (ge_min_s && better_s) begin
              best_vld_q <= 1'b1;  best_tau_q <= tau_q;
              best_d_q   <= d_cur_s; best_s_q <= s_cur_s;
            end
            if (tau_q == TW'(TAU_MAX)) begin
              tau_out_q <= (ge_min_s && better_s) ? tau_q : best_tau_q;
              voiced_q  <= 1'b0;  rvalid_q <= 1'b1;  state_q <= S_DONE;
            end else begin
              tau_q <= tau_q + TW'(1'b1);  s_q <= s_cur_s;
            end
          end
        end
        S_DESCEND: begin
          if (desc_s) begin
            tau_q <= tau_nx_s;  s_q <= s_nx_s;
          end else begin
            tau_out_q <= tau_q;  voiced_q <= 1'b1;  rvalid_q <= 1'b1;  state_q <= S_DONE;
          end
        end
        S_DONE: begin
          if (result_ready_in) begin
            rvalid_q <= 1'b0;  busy_q <= 1'b0;  state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign tau_out          = tau_out_q;
  assign voiced_out       = voiced_q;
  assign result_valid_out = rvalid_q;
  assign busy_out         = busy_q;
  assign filled_out       = filled_q;
  assign overrun_out      = overrun_q;
endmodule

// File: tb/tb_yin_pitch_tracker.sv
// Bench for yin_pitch_tracker: vector table plus hand sequences, checked against
// a direct arithmetic YIN model over the last WINDOW_SIZE stored samples.
module tb_yin_pitch_tracker;
  localparam int SIG_WIDTH   = 9;
  localparam int WINDOW_SIZE = 200;
  localparam int TAU_MIN     = 8;
  localparam int TAU_MAX     = 40;
  localparam int THR_FRAC    = 16;
  localparam int W           = WINDOW_SIZE - TAU_MAX;
  localparam int TW          = $clog2(TAU_MAX+1);
  localparam int BUDGET      = TAU_MAX*(W+4) + 2*TAU_MAX + 8;

  logic                 clk = 1'b0, rst_n = 1'b1;
  logic [SIG_WIDTH-1:0] sig = '0;
  logic                 sig_valid = 1'b0, start = 1'b0, ready = 1'b0;
  logic [THR_FRAC-1:0]  thr = '0;
  logic [TW-1:0]        tau_o;
  logic                 voiced_o, rvalid_o, busy_o, filled_o, overrun_o;

  yin_pitch_tracker #(.SIG_WIDTH(SIG_WIDTH), .WINDOW_SIZE(WINDOW_SIZE), .TAU_MIN(TAU_MIN),
                      .TAU_MAX(TAU_MAX), .THR_FRAC(THR_FRAC)) dut (
    .clk_in(clk), .rst_n_in(rst_n), .sig_in(sig), .sig_in_valid(sig_valid),
    .start_in(start), .threshold_in(thr), .tau_out(tau_o), .voiced_out(voiced_o),
    .result_valid_out(rvalid_o), .result_ready_in(ready), .busy_out(busy_o),
    .filled_out(filled_o), .overrun_out(overrun_o));

  always #5 clk = ~clk;

  typedef struct { int kind; int thr; int exp_tau; int exp_voiced; } vec_t;
  vec_t vecs[6];
  int   n_checks = 0, n_fail = 0;
  int   hist[$];

  task automatic check(input string name, input longint got, input longint exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  function automatic bit dlt(input longint da, input longint ta, input longint sa,
                             input longint db, input longint tb, input longint sb);
    longint na, ma, nb, mb;
    na = (sa == 0) ? 1 : da * ta;  ma = (sa == 0) ? 1 : sa;
    nb = (sb == 0) ? 1 : db * tb;  mb = (sb == 0) ? 1 : sb;
    return na * mb < nb * ma;
  endfunction

  // YIN over the window: d, cumulative S, first crossing + descent, else argmin of d'.
  function automatic void model(input int th, output int etau, output int evoiced);
    longint d[TAU_MAX+1];
    longint s[TAU_MAX+1];
    int     x[WINDOW_SIZE];
    int     base, best;
    base = hist.size() - WINDOW_SIZE;
    for (int i = 0; i < WINDOW_SIZE; i++) x[i] = hist[base+i];
    s[0] = 0;  d[0] = 0;
    for (int t = 1; t <= TAU_MAX; t++) begin
      d[t] = 0;
      for (int j = 0; j < W; j++) d[t] += longint'((x[j]-x[j+t]) * (x[j]-x[j+t]));
      s[t] = s[t-1] + d[t];
    end
    etau = -1;
    for (int t = TAU_MIN; t <= TAU_MAX; t++)
      if (etau < 0 && s[t] != 0 && (d[t] * t * (longint'(1) << THR_FRAC)) < longint'(th) * s[t])
        etau = t;
    if (etau >= 0) begin
      while (etau < TAU_MAX && dlt(d[etau+1], etau+1, s[etau+1], d[etau], etau, s[etau])) etau++;
      evoiced = 1;
    end else begin
      best = TAU_MIN;
      for (int t = TAU_MIN+1; t <= TAU_MAX; t++)
        if (dlt(d[t], t, s[t], d[best], best, s[best])) best = t;
      etau = best;  evoiced = 0;
    end
  endfunction

  // One sample per cycle; entered and left at a negative edge.
  task automatic push(input int v, input bit stored);
    sig = v[SIG_WIDTH-1:0];  sig_valid = 1'b1;
    @(negedge clk);
    sig_valid = 1'b0;
    if (stored) hist.push_back(v);
  endtask

  task automatic fill(input int kind, input int n);
    logic [15:0] lfsr;
    int p, amp, v;
    lfsr = 16'($urandom) | 16'h0001;
    p    = $urandom_range(10, 30);
    amp  = $urandom_range(20, 200);
    for (int i = 0; i < n; i++) begin
      case (kind)
        0: v = ((i % 20) < 10) ? 100 : -100;
        1: v = 0;
        2: begin
          for (int k = 0; k < 9; k++) lfsr = {lfsr[14:0], lfsr[15]^lfsr[13]^lfsr[12]^lfsr[10]};
          v = int'($signed(lfsr[8:0]));
        end
        default: v = (((i % p) < p/2) ? amp : -amp) + int'($urandom_range(0, 6)) - 3;
      endcase
      push(v, 1'b1);
    end
  endtask

  task automatic do_start(input int th);
    start = 1'b1;  thr = th[THR_FRAC-1:0];
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run(input string nm, input int th, input int etau, input int evoiced,
                     input int n_drop, input int hold);
    int mt, mv, n, t0, v0;
    model(th, mt, mv);
    do_start(th);
    check({nm, "_busy"}, busy_o, 1);
    check({nm, "_ovr_clr"}, overrun_o, 0);
    for (int i = 0; i < n_drop; i++) push(int'($urandom_range(0, 255)), 1'b0);
    if (n_drop > 0) check({nm, "_ovr_set"}, overrun_o, 1);
    n = 0;
    while (!rvalid_o && n < BUDGET) begin
      @(negedge clk);
      n++;
    end
    check({nm, "_latency"}, rvalid_o, 1);
    check({nm, "_tau_model"}, tau_o, mt);
    check({nm, "_voiced_model"}, voiced_o, mv);
    if (etau >= 0) check({nm, "_tau"}, tau_o, etau);
    if (evoiced >= 0) check({nm, "_voiced"}, voiced_o, evoiced);
    t0 = int'(tau_o);  v0 = int'(voiced_o);
    for (int i = 0; i < hold; i++) begin
      if (i < 30) push(int'($urandom_range(0, 511)) - 256, 1'b1);
      else @(negedge clk);
      check({nm, "_hold_valid"}, rvalid_o, 1);
      check({nm, "_hold_tau"}, tau_o, t0);
      check({nm, "_hold_voiced"}, voiced_o, v0);
    end
    if (n_drop > 0) check({nm, "_ovr_sticky"}, overrun_o, 1);
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    check({nm, "_hs_valid"}, rvalid_o, 0);
    check({nm, "_hs_busy"}, busy_o, 0);
  endtask

  initial begin
    vecs[0] = '{0, 32'h4000, 20, 1};
    vecs[1] = '{1, 32'h4000, TAU_MIN, 0};
    vecs[2] = '{2, 32'h0100, -1, 0};
    vecs[3] = '{2, 32'h0100, -1, 0};
    vecs[4] = '{3, -1, -1, -1};
    vecs[5] = '{3, -1, -1, -1};

    #2 rst_n = 1'b0;
    #1;
    check("rst_tau", tau_o, 0);        check("rst_voiced", voiced_o, 0);
    check("rst_valid", rvalid_o, 0);   check("rst_busy", busy_o, 0);
    check("rst_filled", filled_o, 0);  check("rst_overrun", overrun_o, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // One sample short of full: start must be ignored.
    fill(3, WINDOW_SIZE-1);
    check("short_filled", filled_o, 0);
    do_start(16'h4000);
    repeat (3) @(negedge clk);
    check("short_busy", busy_o, 0);
    push(int'($urandom_range(0, 200)) - 100, 1'b1);
    check("full_filled", filled_o, 1);
    run("hold", 16'h4000, -1, -1, 3, 50);
    run("after_done", 16'h2000, -1, -1, 0, 0);

    for (int i = 0; i < 6; i++) begin
      int th;
      th = (vecs[i].thr < 0) ? int'($urandom_range(16'h1000, 16'h8000)) : vecs[i].thr;
      fill(vecs[i].kind, WINDOW_SIZE);
      run($sformatf("vec%0d", i), th, vecs[i].exp_tau, vecs[i].exp_voiced, 0, 0);
    end

    // Reset in the middle of DIFF aborts everything and forgets the fill state.
    fill(0, WINDOW_SIZE);
    do_start(16'h4000);
    push(5, 1'b0);
    repeat (100) @(negedge clk);
    check("mid_busy", busy_o, 1);
    check("mid_overrun", overrun_o, 1);
    #2 rst_n = 1'b0;
    #1;
    check("abort_tau", tau_o, 0);        check("abort_voiced", voiced_o, 0);
    check("abort_valid", rvalid_o, 0);   check("abort_busy", busy_o, 0);
    check("abort_filled", filled_o, 0);  check("abort_overrun", overrun_o, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_start(16'h4000);
    repeat (3) @(negedge clk);
    check("norefill_busy", busy_o, 0);
    check("norefill_filled", filled_o, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/yin_pitch_tracker.md
Name: yin_pitch_tracker

Overview:
- Parametrised successor to the single-channel YIN pitch estimator.
- Keeps a circular window of signed audio samples and computes the difference function d(tau) over a fixed integration length. It then searches the cumulative-mean-normalised difference (CMNDF) for the first threshold crossing, descends to that dip's local minimum, and falls back to the global minimum when no crossing exists.
- Emits an integer lag plus a voiced flag through a valid/ready handshake; the downstream divider converts lag to frequency.

Parameters:
- SIG_WIDTH, 9: signed sample width (two's complement).
- WINDOW_SIZE, 500: ring-buffer depth in samples.
- TAU_MIN, 8: smallest lag searched; must satisfy 1 <= TAU_MIN < TAU_MAX.
- TAU_MAX, 80: largest lag computed and searched; must be < WINDOW_SIZE.
- THR_FRAC, 16: fractional bits of threshold_in (unsigned Q0.THR_FRAC).

Ports:
- clk_in, in, 1: single clock.
- rst_n_in, in, 1: asynchronous active-low reset.
- sig_in, in, SIG_WIDTH: signed sample.
- sig_in_valid, in, 1: sample strobe.
- start_in, in, 1: request an estimate; pulse.
- threshold_in, in, THR_FRAC: CMNDF threshold; sampled when start_in is accepted.
- tau_out, out, $clog2(TAU_MAX+1): detected lag.
- voiced_out, out, 1: 1 = threshold crossing found; 0 = global-minimum fallback.
- result_valid_out, out, 1: result present.
- result_ready_in, in, 1: consumer accepts the result.
- busy_out, out, 1: high from start acceptance until the result handshake completes.
- filled_out, out, 1: ring buffer holds at least WINDOW_SIZE samples since reset.
- overrun_out, out, 1: sticky; a sample was dropped during computation.

Behaviour:
- Reset (async assert, sync release) sets:
  - all outputs to 0; state IDLE;
  - write pointer and fill count to 0.
  - Buffer contents need not be cleared.
- Definitions:
  - W = WINDOW_SIZE - TAU_MAX.
  - x[0] is the oldest sample in the window at start.
  - d(tau) = sum over j = 0..W-1 of (x[j] - x[j+tau])^2, for tau = 1..TAU_MAX.
  - S(tau) = sum over k = 1..tau of d(k).
  - Differences are computed at SIG_WIDTH+1 bits (no wrap).
  - Accumulators are 2*(SIG_WIDTH+1)+$clog2(W)+$clog2(TAU_MAX)+1 bits, so overflow is impossible.
- Sample capture:
  - In IDLE and DONE, sig_in_valid writes the buffer at the write pointer; the pointer wraps from WINDOW_SIZE-1 to 0.
  - The fill count saturates at WINDOW_SIZE.
  - In DIFF, SEARCH and DESCEND, samples are dropped and overrun_out is set.
  - overrun_out clears only when the next start is accepted.
- start_in is accepted only in IDLE with filled_out = 1; otherwise it is ignored with no side effects.
  - Start and sig_in_valid in the same IDLE cycle: the sample is written first, and the window includes it.
  - Acceptance latches threshold_in and the window base (the write pointer after that write), asserts busy_out, and enters DIFF.
- DIFF:
  - One (x[j], x[j+tau]) pair is read per cycle through a pipelined subtract/square/accumulate.
  - tau runs 1..TAU_MAX and j runs 0..W-1; read indices wrap modulo WINDOW_SIZE.
  - The pipeline must drain before each d(tau) is stored; no term may be lost or double-counted at tau boundaries.
  - Total busy time from acceptance to result_valid_out is at most TAU_MAX*(W+4) + 2*TAU_MAX + 8 cycles.
- SEARCH, tau = 1..TAU_MAX, one tau per cycle:
  - S is accumulated for every tau; tests apply only for tau >= TAU_MIN.
  - Crossing test, division-free: d(tau) * tau * 2^THR_FRAC < thr * S(tau).
  - S(tau) = 0 means no crossing.
  - On the first crossing, go to DESCEND.
  - In parallel, track the global minimum of d'(tau) = d(tau)*tau/S(tau) by cross-multiplication. Treat d' = 1 when S = 0. Ties keep the smaller tau.
- DESCEND:
  - While tau < TAU_MAX and d'(tau+1) < d'(tau) (cross-multiplied, strict), increment tau.
  - Then latch tau_out = tau and voiced_out = 1, and go to DONE.
- SEARCH end without a crossing: tau_out = global-minimum tau, voiced_out = 0, go to DONE.
- DONE:
  - result_valid_out = 1; tau_out and voiced_out are held stable until result_valid_out && result_ready_in.
  - On that handshake, on the same edge: result_valid_out and busy_out drop, and the state returns to IDLE.
- Reset mid-computation aborts immediately with no result.
- Fill state is lost on reset: filled_out must reassert (WINDOW_SIZE samples) before a start is accepted.

Test Plan:
- Square wave, period 20, ±100, 500 samples; threshold 0x4000 (0.25); start -> tau_out = 20, voiced_out = 1. The threshold crossing occurs before 20, so DESCEND is exercised.
- All-zero input, start -> tau_out = TAU_MIN (8), voiced_out = 0.
- White-noise (LFSR) input, threshold 0x0100 -> voiced_out = 0; tau_out equals the bench model's argmin of d' over 8..80.
- Start with only 499 samples -> ignored, busy_out stays 0. Send 1 more sample plus start -> accepted.
- result_ready_in held low 50 cycles after result_valid_out -> outputs stable for all 50 cycles. Samples sent in DONE are stored; samples sent during DIFF set overrun_out, which clears on the next start.
- rst_n_in pulsed low mid-DIFF -> all outputs 0 asynchronously. A later start without refilling is ignored.
